// File: rtl/s_o_sequencer.sv
// s_o_sequencer: plays a latched pattern of up to MAX_LEN S/O symbols,
// issuing one request per symbol over the func_start/func_done handshake.
// Optional build macro S_O_SEQ_REPEAT_EN adds cmd_repeat, which replays the
// whole pattern cmd_repeat+1 times.
//
// Handshake: func_start holds a non-zero symbol code (10 = S, 01 = O) from
// the cycle the request is issued until func_done=1 is sampled on a rising
// edge in ISSUE; func_start drops to 00 on that same edge. func_done may be
// high in the first cycle of the request (zero latency) and is ignored in
// every other state.
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 GAP, 3 DONE.
module s_o_sequencer #(
  parameter int MAX_LEN    = 8,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_start,
  input  logic [MAX_LEN-1:0] cmd_pattern,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_abort,
`ifdef S_O_SEQ_REPEAT_EN
  input  logic [3:0]         cmd_repeat,
`endif
  output logic               cmd_busy,
  output logic               cmd_done,
  output logic [LEN_W-1:0]   sym_index,
  output logic [1:0]         func_start,
  input  logic               func_done,
  output logic [1:0]         dbg_state
);

  // Idle cycles between symbols; at least one so func_start always returns to 00.
  localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [GW-1:0]      gap_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         fs_q;
`ifdef S_O_SEQ_REPEAT_EN
  logic [3:0]         rep_q;
`endif

  logic [LEN_W-1:0]   clamp_len_d;
  logic               cur_bit_d;
  logic               last_sym_d;

  // Clamp the requested length and select the pattern bit for the current index.
  always_comb begin
    clamp_len_d = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    cur_bit_d   = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (idx_q == LEN_W'(k)) cur_bit_d = pat_q[k];
    end
    last_sym_d  = (idx_q == len_q - 1'b1);
  end

  // Sequencer FSM with registered outputs; abort outranks everything outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fs_q      <= 2'b00;
`ifdef S_O_SEQ_REPEAT_EN
      rep_q     <= '0;
`endif
    end else if (state_q == IDLE) begin
      if (cmd_start) begin
        pat_q  <= cmd_pattern;
        len_q  <= clamp_len_d;
        idx_q  <= '0;
        busy_q <= 1'b1;
`ifdef S_O_SEQ_REPEAT_EN
        rep_q  <= cmd_repeat;
`endif
        if (clamp_len_d == '0) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= ISSUE;
          fs_q    <= cmd_pattern[0] ? 2'b10 : 2'b01;
        end
      end
    end else if (cmd_abort) begin
      state_q <= IDLE;
      fs_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ISSUE: begin
          if (func_done) begin
            fs_q <= 2'b00;
            if (last_sym_d) begin
`ifdef S_O_SEQ_REPEAT_EN
              if (rep_q != '0) begin
                rep_q     <= rep_q - 1'b1;
                idx_q     <= '0;
                gap_cnt_q <= GW'(GAP_N - 1);
                state_q   <= GAP;
              end else begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
`else
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              idx_q     <= idx_q + 1'b1;
              gap_cnt_q <= GW'(GAP_N - 1);
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            fs_q    <= cur_bit_d ? 2'b10 : 2'b01;
            state_q <= ISSUE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_busy   = busy_q;
  assign cmd_done   = done_q;
  assign sym_index  = idx_q;
  assign func_start = fs_q;
  assign dbg_state  = state_q;

endmodule
